// File: rtl/mem_access_seq.sv
// -----------------------------------------------------------------------------
// mem_access_seq
//
// Sequencer for single load/store transfers between the working register and
// the external 16-bit data bus. It steers the direction controls of the
// downstream bidirectional data port, drives the memory address and active-low
// strobes, inserts wait states, and pulses the working-register load enable.
//
// Transfer: IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1) -> HOLD -> TURN (TURN_CYCLES)
// -> IDLE. TURN is skipped when TURN_CYCLES = 0.
//
// Handshake: req is a level request sampled only in IDLE. When it is sampled
// high there, the transfer is accepted on that edge and addr/ld_st are latched.
// There is no ready/ack; busy low means the next req will be accepted, and a
// req seen while busy is not queued but flagged on req_drop for that cycle.
//
// Parameters
//   ADDR_W       address width
//   WAIT_CYCLES  extra ACCESS cycles beyond the first (0..15)
//   TURN_CYCLES  idle cycles after HOLD with both directions off (0..3)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        transfer request (sampled in IDLE only)
//   ld_st      1 = load (bus -> wreg), 0 = store (wreg -> bus)
//   addr       transfer address
//   busy       high in every state except IDLE
//   done       one-cycle pulse in HOLD
//   req_drop   high in any cycle where req is high outside IDLE
//   wreg_load  working-register load enable, last ACCESS cycle of a load
//   mem_write  data port direction bus -> wreg
//   mem_read   data port direction wreg -> bus
//   mem_addr   registered memory address
//   mem_oe_n   memory output enable, active low
//   mem_we_n   memory write enable, active low
//   state_dbg  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module mem_access_seq #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              ld_st,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              req_drop,
    output logic              wreg_load,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_HOLD   = 3'd3,
        S_TURN   = 3'd4
    } state_t;

    // The down-counter is reloaded on entry to ACCESS and TURN; the state is
    // left when it reads zero, so the reload value is (cycles - 1).
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [3:0] TURN_INIT = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                load_q, load_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic                done_q, done_d;
    logic                wl_q, wl_d;
    logic                mw_q, mw_d;
    logic                mr_q, mr_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    load_d  = ld_st;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = WAIT_INIT;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (TURN_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TURN;
                    cnt_d   = TURN_INIT;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the *next* state so that every direction/strobe
    // output comes straight from a flop in the cycle the state is entered.
    always_comb begin
        done_d = 1'b0;
        wl_d   = 1'b0;
        mw_d   = 1'b0;
        mr_d   = 1'b0;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        case (state_d)
            S_SETUP: begin
                // Store drives the bus a cycle early so data is stable
                // before the write strobe falls.
                mr_d = ~load_d;
            end
            S_ACCESS: begin
                if (load_d) begin
                    oe_n_d = 1'b0;
                    mw_d   = 1'b1;
                    // cnt_d == 0 marks the final ACCESS cycle.
                    wl_d   = (cnt_d == 4'd0);
                end else begin
                    we_n_d = 1'b0;
                    mr_d   = 1'b1;
                end
            end
            S_HOLD: begin
                done_d = 1'b1;
                // Store keeps driving for data hold after the strobe rises.
                mr_d   = ~load_d;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            wl_q    <= 1'b0;
            mw_q    <= 1'b0;
            mr_q    <= 1'b0;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            wl_q    <= wl_d;
            mw_q    <= mw_d;
            mr_q    <= mr_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    // Dropped-request flag follows req in the same cycle it is seen.
    assign req_drop  = req && (state_q != S_IDLE);
    assign done      = done_q;
    assign wreg_load = wl_q;
    assign mem_write = mw_q;
    assign mem_read  = mr_q;
    assign mem_oe_n  = oe_n_q;
    assign mem_we_n  = we_n_q;
    assign mem_addr  = addr_q;
    assign state_dbg = state_q;

    // Bus-safety invariants.
    a_dir_excl : assert property (@(posedge clk) disable iff (rst) !(mem_write && mem_read));
    a_strb_excl: assert property (@(posedge clk) disable iff (rst) !(!mem_oe_n && !mem_we_n));
    a_wl_dir   : assert property (@(posedge clk) disable iff (rst) !(wreg_load && !mem_write));

endmodule

// File: tb/tb_mem_access_seq.sv
// -----------------------------------------------------------------------------
// Testbench for mem_access_seq. Three instances share the inputs:
//   [0] defaults (W=2, T=1), [1] W=0 T=0, [2] W=15 T=1.
// Each scenario starts from reset and checks only its own instance per cycle;
// the bus-safety invariants are checked on every instance every cycle.
// Control outputs are packed as
//   {busy, done, req_drop, wreg_load, mem_write, mem_read, mem_oe_n, mem_we_n}.
// Cycle k of a scenario is the cycle after k edges, the request being
// accepted at the edge that ends cycle 0.
// -----------------------------------------------------------------------------
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        ld_st;
    logic [15:0] addr;

    logic        busy_w[3];
    logic        done_w[3];
    logic        drop_w[3];
    logic        wl_w[3];
    logic        mw_w[3];
    logic        mr_w[3];
    logic        oe_n_w[3];
    logic        we_n_w[3];
    logic [15:0] maddr_w[3];
    logic [2:0]  st_w[3];

    int n_checks = 0;
    int n_errors = 0;
    logic inv_en = 1'b0;

    always #5 clk = ~clk;

    mem_access_seq #(.ADDR_W(16), .WAIT_CYCLES(2), .TURN_CYCLES(1)) u_def (
        .clk(clk), .rst(rst), .req(req), .ld_st(ld_st), .addr(addr),
        .busy(busy_w[0]), .done(done_w[0]), .req_drop(drop_w[0]), .wreg_load(wl_w[0]),
        .mem_write(mw_w[0]), .mem_read(mr_w[0]), .mem_addr(maddr_w[0]),
        .mem_oe_n(oe_n_w[0]), .mem_we_n(we_n_w[0]), .state_dbg(st_w[0]));

    mem_access_seq #(.ADDR_W(16), .WAIT_CYCLES(0), .TURN_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req), .ld_st(ld_st), .addr(addr),
        .busy(busy_w[1]), .done(done_w[1]), .req_drop(drop_w[1]), .wreg_load(wl_w[1]),
        .mem_write(mw_w[1]), .mem_read(mr_w[1]), .mem_addr(maddr_w[1]),
        .mem_oe_n(oe_n_w[1]), .mem_we_n(we_n_w[1]), .state_dbg(st_w[1]));

    mem_access_seq #(.ADDR_W(16), .WAIT_CYCLES(15), .TURN_CYCLES(1)) u_w15 (
        .clk(clk), .rst(rst), .req(req), .ld_st(ld_st), .addr(addr),
        .busy(busy_w[2]), .done(done_w[2]), .req_drop(drop_w[2]), .wreg_load(wl_w[2]),
        .mem_write(mw_w[2]), .mem_read(mr_w[2]), .mem_addr(maddr_w[2]),
        .mem_oe_n(oe_n_w[2]), .mem_we_n(we_n_w[2]), .state_dbg(st_w[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] out_bits(input int i);
        return {busy_w[i], done_w[i], drop_w[i], wl_w[i],
                mw_w[i], mr_w[i], oe_n_w[i], we_n_w[i]};
    endfunction

    // Drive one cycle of inputs, check instance outputs, advance to next cycle.
    task automatic cyc(input int inst, input logic r, input logic rq, input logic ld,
                       input logic [15:0] ad, input logic [7:0] exp_bits,
                       input logic [15:0] exp_addr, input string tag);
        rst   = r;
        req   = rq;
        ld_st = ld;
        addr  = ad;
        #1;
        check_val({tag, "_ctl"}, {24'd0, out_bits(inst)}, {24'd0, exp_bits});
        check_val({tag, "_addr"}, {16'd0, maddr_w[inst]}, {16'd0, exp_addr});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 1'b0;
        ld_st = 1'b0;
        addr  = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Bus-safety invariants on all instances.
    always @(negedge clk) begin
        if (inv_en) begin
            for (int i = 0; i < 3; i++) begin
                check_val($sformatf("inv_dir%0d", i), {31'd0, mw_w[i] & mr_w[i]}, 32'd0);
                check_val($sformatf("inv_strb%0d", i), {31'd0, ~oe_n_w[i] & ~we_n_w[i]}, 32'd0);
                check_val($sformatf("inv_wl%0d", i), {31'd0, wl_w[i] & ~mw_w[i]}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [7:0] E_IDLE = 8'h03;

    initial begin : main
        logic [7:0] exp_ld[7];
        logic [7:0] exp_st0[4];
        logic [7:0] exp_bb[14];
        logic [7:0] e;

        exp_ld  = '{8'h83, 8'h89, 8'h89, 8'h99, 8'hC3, 8'h83, 8'h03};
        exp_st0 = '{8'h87, 8'h86, 8'hC7, 8'h03};
        exp_bb  = '{8'h83, 8'h89, 8'hA9, 8'h99, 8'hC3, 8'h83, 8'h03,
                    8'h87, 8'h86, 8'h86, 8'h86, 8'hC7, 8'h83, 8'h03};

        rst   = 1'b1;
        req   = 1'b0;
        ld_st = 1'b0;
        addr  = 16'h0000;
        @(posedge clk);
        #1;
        do_reset();
        inv_en = 1'b1;

        // Reset defaults on every instance, then idle for 5 cycles.
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst_ctl%0d", i), {24'd0, out_bits(i)}, {24'd0, E_IDLE});
            check_val($sformatf("rst_addr%0d", i), {16'd0, maddr_w[i]}, 32'd0);
        end
        for (int k = 0; k < 5; k++)
            cyc(0, 1'b0, 1'b0, 1'b0, 16'h0000, E_IDLE, 16'h0000, $sformatf("idle_c%0d", k));

        // Load at defaults.
        cyc(0, 1'b0, 1'b1, 1'b1, 16'h1234, E_IDLE, 16'h0000, "ld_c0");
        for (int k = 1; k <= 7; k++)
            cyc(0, 1'b0, 1'b0, 1'b0, 16'h0000, exp_ld[k-1], 16'h1234, $sformatf("ld_c%0d", k));

        // Store with W=0, T=0.
        do_reset();
        cyc(1, 1'b0, 1'b1, 1'b0, 16'h0010, E_IDLE, 16'h0000, "st_c0");
        for (int k = 1; k <= 4; k++)
            cyc(1, 1'b0, 1'b0, 1'b0, 16'h0000, exp_st0[k-1], 16'h0010, $sformatf("st_c%0d", k));

        // Back-to-back load then store, with a dropped request in cycle 3.
        do_reset();
        cyc(0, 1'b0, 1'b1, 1'b1, 16'h4321, E_IDLE, 16'h0000, "bb_c0");
        for (int k = 1; k <= 14; k++) begin
            if (k == 3)
                cyc(0, 1'b0, 1'b1, 1'b0, 16'h5555, exp_bb[k-1], 16'h4321, $sformatf("bb_c%0d", k));
            else if (k == 7)
                cyc(0, 1'b0, 1'b1, 1'b0, 16'h0ABC, exp_bb[k-1], 16'h4321, $sformatf("bb_c%0d", k));
            else
                cyc(0, 1'b0, 1'b0, 1'b1, 16'h0000, exp_bb[k-1],
                    (k < 8) ? 16'h4321 : 16'h0ABC, $sformatf("bb_c%0d", k));
        end

        // Reset asserted during cycle 3 of a load.
        do_reset();
        cyc(0, 1'b0, 1'b1, 1'b1, 16'h2222, E_IDLE, 16'h0000, "mr_c0");
        cyc(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h83, 16'h2222, "mr_c1");
        cyc(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h89, 16'h2222, "mr_c2");
        cyc(0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h89, 16'h2222, "mr_c3");
        for (int k = 4; k <= 8; k++)
            cyc(0, 1'b0, 1'b0, 1'b0, 16'h0000, E_IDLE, 16'h0000, $sformatf("mr_c%0d", k));

        // W=15: ACCESS spans cycles 2..17, done in cycle 18.
        do_reset();
        cyc(2, 1'b0, 1'b1, 1'b1, 16'h00F0, E_IDLE, 16'h0000, "w15_c0");
        for (int k = 1; k <= 20; k++) begin
            if (k == 1)       e = 8'h83;
            else if (k <= 16) e = 8'h89;
            else if (k == 17) e = 8'h99;
            else if (k == 18) e = 8'hC3;
            else if (k == 19) e = 8'h83;
            else              e = E_IDLE;
            cyc(2, 1'b0, 1'b0, 1'b0, 16'h0000, e, 16'h00F0, $sformatf("w15_c%0d", k));
        end

        inv_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
